// File: rtl/pseudo_spi_rx_intf.sv
// Pseudo-SPI capture interface: latches the analog scan chain, clocks it out with
// two-phase non-overlapping clocks, and writes LSB-first bytes to SRAM at descending addresses.
module pseudo_spi_rx_intf #(
   parameter int MEMORY_DATA_WIDTH = 8,
   parameter int MEMORY_ADDR_WIDTH = 9,
   parameter int RESERVED_DATA_LEN = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         BGN,
   input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
   input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
   input  logic [7:0]                   FREQ_DIV,
   input  logic                         SPI_SI,
   output logic                         SCLK1,
   output logic                         SCLK2,
   output logic                         LAT,
   output logic                         is_i_addr,
   output logic [MEMORY_ADDR_WIDTH-1:0] A,
   output logic [MEMORY_DATA_WIDTH-1:0] PO,
   output logic                         D_WE,
   output logic                         spi_is_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_ADDR  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int                BIT_W    = $clog2(MEMORY_DATA_WIDTH);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(MEMORY_DATA_WIDTH - 1);

   logic [2:0]                   state;
   logic [MEMORY_ADDR_WIDTH-1:0] addr;
   logic [RESERVED_DATA_LEN-1:0] len;
   logic [7:0]                   div;
   logic [7:0]                   cnt;
   logic [1:0]                   phase;
   logic [BIT_W-1:0]             bit_idx;
   logic [MEMORY_DATA_WIDTH-1:0] sreg;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // in this block sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         addr    <= '0;
         len     <= '0;
         div     <= '0;
         cnt     <= '0;
         phase   <= '0;
         bit_idx <= '0;
         sreg    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (BGN) begin
                  addr    <= ADDR_BGN;
                  len     <= DATA_LEN;
                  div     <= FREQ_DIV;
                  cnt     <= '0;
                  phase   <= '0;
                  bit_idx <= '0;
                  sreg    <= '0;
                  state   <= (DATA_LEN == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               if (!BGN) begin
                  state <= S_IDLE;
               end else if (cnt == div) begin
                  cnt     <= '0;
                  phase   <= '0;
                  bit_idx <= '0;
                  state   <= S_SHIFT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_SHIFT: begin
               if (!BGN) begin
                  state <= S_IDLE;
               end else if (cnt == div) begin
                  cnt   <= '0;
                  phase <= phase + 2'd1;
                  // Sample on the last cycle of the quiet phase, just before SCLK1 rises.
                  if (phase == 2'd0)
                     sreg <= {SPI_SI, sreg[MEMORY_DATA_WIDTH-1:1]};
                  if (phase == 2'd3) begin
                     if (bit_idx == LAST_BIT)
                        state <= S_WRITE;
                     else
                        bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_WRITE: state <= BGN ? S_ADDR : S_IDLE;
            S_ADDR: begin
               if (!BGN) begin
                  state <= S_IDLE;
               end else begin
                  addr    <= addr - 1'b1;
                  len     <= len - 1'b1;
                  cnt     <= '0;
                  phase   <= '0;
                  bit_idx <= '0;
                  state   <= (len != RESERVED_DATA_LEN'(1)) ? S_SHIFT : S_DONE;
               end
            end
            S_DONE: if (!BGN) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      SCLK1       = 1'b0;
      SCLK2       = 1'b0;
      LAT         = 1'b0;
      A           = '0;
      PO          = '0;
      D_WE        = 1'b1;
      spi_is_done = 1'b0;
      case (state)
         S_LOAD:  LAT = 1'b1;
         S_SHIFT: begin
            SCLK1 = (phase == 2'd1);
            SCLK2 = (phase == 2'd3);
         end
         S_WRITE: begin
            A    = addr;
            PO   = sreg;
            D_WE = 1'b0;
         end
         S_DONE:  spi_is_done = 1'b1;
         default: ;
      endcase
   end

   assign is_i_addr = 1'b0;

endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// Bench for pseudo_spi_rx_intf: a scan-chain device model feeds SPI_SI, a monitor
// collects pulse/write statistics, and directed plus random transfers are checked.
module tb_pseudo_spi_rx_intf;

   logic       CLK = 1'b0;
   logic       RST;
   logic       BGN;
   logic [8:0] ADDR_BGN;
   logic [7:0] DATA_LEN;
   logic [7:0] FREQ_DIV;
   logic       SPI_SI = 1'b0;
   logic       SCLK1, SCLK2, LAT, is_i_addr, D_WE, spi_is_done;
   logic [8:0] A;
   logic [7:0] PO;

   pseudo_spi_rx_intf dut (
      .CLK(CLK), .RST(RST), .BGN(BGN), .ADDR_BGN(ADDR_BGN), .DATA_LEN(DATA_LEN),
      .FREQ_DIV(FREQ_DIV), .SPI_SI(SPI_SI), .SCLK1(SCLK1), .SCLK2(SCLK2), .LAT(LAT),
      .is_i_addr(is_i_addr), .A(A), .PO(PO), .D_WE(D_WE), .spi_is_done(spi_is_done)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Device scan chain: bytes presented LSB-first, one bit per SCLK2 pulse, reloaded by LAT.
   logic [7:0] tx_bytes[$];
   int         dev_idx = 0;
   logic       sclk2_q = 1'b0;

   // Monitor statistics, cleared whenever the main sequence announces a new transfer.
   int         xfer_id = 0, seen_id = 0, mon_cyc = 0;
   int         n_s1, n_s2, n_lat, lat_w, s1_run, s1_wmin, s1_wmax, lat_run;
   int         we_run, we_wmax, low_run, min_gap;
   bit         had_pulse, overlap;
   logic       prev_s1 = 1'b0, prev_s2 = 1'b0;
   logic [8:0] wr_a[$];
   logic [7:0] wr_d[$];
   int         wr_t[$];

   always @(posedge CLK) begin
      #1;
      mon_cyc++;
      if (seen_id != xfer_id) begin
         seen_id = xfer_id;
         n_s1 = 0; n_s2 = 0; n_lat = 0; lat_w = 0; s1_run = 0; s1_wmin = 1000; s1_wmax = 0;
         lat_run = 0; we_run = 0; we_wmax = 0; low_run = 0; min_gap = 1000;
         had_pulse = 1'b0; overlap = 1'b0;
         wr_a.delete(); wr_d.delete(); wr_t.delete();
      end
      if (LAT) dev_idx = 0;
      else if (sclk2_q && !SCLK2) dev_idx++;
      sclk2_q = SCLK2;
      SPI_SI = (dev_idx < tx_bytes.size() * 8) ? tx_bytes[dev_idx / 8][dev_idx % 8] : 1'b0;

      if (SCLK1 && SCLK2) overlap = 1'b1;
      if ((SCLK1 && !prev_s1) || (SCLK2 && !prev_s2)) begin
         if (had_pulse && low_run < min_gap) min_gap = low_run;
         had_pulse = 1'b1;
         low_run = 0;
      end
      if (!SCLK1 && !SCLK2) low_run++;
      if (SCLK1 && !prev_s1) n_s1++;
      if (SCLK2 && !prev_s2) n_s2++;
      if (SCLK1) s1_run++;
      else if (s1_run > 0) begin
         if (s1_run < s1_wmin) s1_wmin = s1_run;
         if (s1_run > s1_wmax) s1_wmax = s1_run;
         s1_run = 0;
      end
      if (LAT) lat_run++;
      else if (lat_run > 0) begin
         n_lat++; lat_w = lat_run; lat_run = 0;
      end
      if (!D_WE) begin
         we_run++;
         wr_a.push_back(A); wr_d.push_back(PO); wr_t.push_back(mon_cyc);
      end else if (we_run > 0) begin
         if (we_run > we_wmax) we_wmax = we_run;
         we_run = 0;
      end
      prev_s1 = SCLK1;
      prev_s2 = SCLK2;
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sclk1"}, SCLK1, 1'b0);
      check({tag, "_sclk2"}, SCLK2, 1'b0);
      check({tag, "_lat"}, LAT, 1'b0);
      check({tag, "_a"}, A, 9'h000);
      check({tag, "_po"}, PO, 8'h00);
      check({tag, "_dwe"}, D_WE, 1'b1);
      check({tag, "_done"}, spi_is_done, 1'b0);
      check({tag, "_iaddr"}, is_i_addr, 1'b0);
   endtask

   // Drive request inputs just after a falling edge; the next rising edge samples BGN.
   task automatic begin_xfer(input int f, input int n, input int addr);
      @(negedge CLK);
      FREQ_DIV = f[7:0];
      DATA_LEN = n[7:0];
      ADDR_BGN = addr[8:0];
      BGN = 1'b1;
      xfer_id++;
   endtask

   // Wait for DONE, compare timing and all collected activity with the expected transfer.
   task automatic wait_check(input string tag, input int f, input int n, input int addr);
      int cyc = 0;
      bit done_seen = 1'b0;
      int exp_done = (n == 0) ? 1 : 1 + (f + 1) + n * (32 * (f + 1) + 2);
      logic [8:0] ea;
      while (!done_seen && cyc < exp_done + 50) begin
         @(negedge CLK);
         cyc++;
         if (cyc == 1) check({tag, "_lat_start"}, LAT, (n != 0));
         if (spi_is_done) done_seen = 1'b1;
      end
      check({tag, "_done_cycle"}, done_seen ? cyc : -1, exp_done);
      check({tag, "_n_writes"}, wr_a.size(), n);
      for (int k = 0; k < n && k < wr_a.size(); k++) begin
         ea = addr[8:0] - k[8:0];
         check($sformatf("%s_wr%0d_addr", tag, k), wr_a[k], ea);
         check($sformatf("%s_wr%0d_data", tag, k), wr_d[k], tx_bytes[k]);
         if (k > 0) check($sformatf("%s_wr%0d_spacing", tag, k), wr_t[k] - wr_t[k-1], 32 * (f + 1) + 2);
      end
      check({tag, "_n_sclk1"}, n_s1, 8 * n);
      check({tag, "_n_sclk2"}, n_s2, 8 * n);
      check({tag, "_n_lat"}, n_lat, (n != 0) ? 1 : 0);
      check({tag, "_overlap"}, overlap, 1'b0);
      if (n != 0) begin
         check({tag, "_lat_width"}, lat_w, f + 1);
         check({tag, "_sclk1_wmin"}, s1_wmin, f + 1);
         check({tag, "_sclk1_wmax"}, s1_wmax, f + 1);
         check({tag, "_min_gap_ok"}, (min_gap >= f + 1), 1'b1);
         check({tag, "_dwe_width"}, we_wmax, 1);
      end
      BGN = 1'b0;
      @(negedge CLK);
      check({tag, "_idle_after"}, spi_is_done, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int f, n, a, s1_snap, s2_snap;
      RST = 1'b1; BGN = 1'b0; ADDR_BGN = '0; DATA_LEN = '0; FREQ_DIV = '0;
      repeat (3) @(negedge CLK);
      check_reset_outputs("por");
      RST = 1'b0;

      // Single byte, bits 1,0,1,1,0,0,1,0 first to last.
      tx_bytes = '{8'h4D};
      begin_xfer(0, 1, 'h010);
      wait_check("single", 0, 1, 'h010);

      // Divider with address wrap.
      tx_bytes = '{8'h81, 8'h7E, 8'hC3};
      begin_xfer(2, 3, 'h001);
      wait_check("wrap", 2, 3, 'h001);

      // Zero length.
      tx_bytes.delete();
      begin_xfer(1, 0, 'h0AA);
      wait_check("zero", 1, 0, 'h0AA);

      // Multi-byte streaming.
      tx_bytes = '{8'hA5, 8'h3C};
      begin_xfer(0, 2, 'h100);
      wait_check("multi", 0, 2, 'h100);

      // Abort during bit 4 of the first byte (bit b phase p occupies cycle 2+4b+p).
      tx_bytes = '{8'h5A, 8'h96};
      begin_xfer(0, 2, 'h020);
      repeat (19) @(negedge CLK);
      BGN = 1'b0;
      @(negedge CLK);
      check("abort_sclk1", SCLK1, 1'b0);
      check("abort_done", spi_is_done, 1'b0);
      repeat (5) @(negedge CLK);
      s1_snap = n_s1; s2_snap = n_s2;
      check("abort_n_sclk1", s1_snap, 5);
      check("abort_n_sclk2", s2_snap, 4);
      check("abort_no_write", wr_a.size(), 0);
      begin_xfer(0, 2, 'h020);
      wait_check("restart", 0, 2, 'h020);

      // Synchronous reset mid-SHIFT with BGN held high; a fresh transfer follows.
      tx_bytes = '{8'h33, 8'hE1};
      begin_xfer(1, 2, 'h050);
      repeat (20) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check_reset_outputs("midrst");
      RST = 1'b0;
      xfer_id++;
      wait_check("after_rst", 1, 2, 'h050);

      // Randomized transfers.
      for (int r = 0; r < 5; r++) begin
         f = $urandom_range(0, 3);
         n = $urandom_range(1, 4);
         a = $urandom_range(0, 511);
         tx_bytes.delete();
         for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
         begin_xfer(f, n, a);
         wait_check($sformatf("rnd%0d", r), f, n, a);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
